// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_pkg                                                      |
// | Brief  : Shared opcodes, FSM encoding and data width for the          |
// |          two-requester logic-unit arbiter.                            |
// | Rev    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 16;

  // Bitwise operation selectors
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [1:0]        opcode_t;

  // One captured operation together with the requester that issued it
  typedef struct packed {
    data_t   a;
    data_t   b;
    opcode_t op;
    logic    id;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : logic_unit_arbiter_if                                        |
// | Brief  : Request/response bus of the logic-unit arbiter. The master   |
// |          side is the requesters plus consumer; the slave side is the  |
// |          arbiter itself.                                              |
// | Rev    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------+
interface logic_unit_arbiter_if;
  import alu_pkg::*;

  logic        req0_valid;
  logic        req0_ready;
  data_t       req0_a;
  data_t       req0_b;
  opcode_t     req0_op;

  logic        req1_valid;
  logic        req1_ready;
  data_t       req1_a;
  data_t       req1_b;
  opcode_t     req1_op;

  logic        rsp_valid;
  logic        rsp_ready;
  data_t       rsp_data;
  logic        rsp_id;

  logic        busy;
  logic [15:0] op_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    input  busy, op_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    output busy, op_count
  );

endinterface
`default_nettype wire

// File: rtl/logic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : logic_unit                                                   |
// | Brief  : Purely combinational 16-bit bitwise AND/NAND/OR/XOR.         |
// | Rev    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------+
module logic_unit
  import alu_pkg::*;
(
  input  data_t   a_i,
  input  data_t   b_i,
  input  opcode_t op_i,
  output data_t   y_o
);

  // Select the bitwise function named by the opcode
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : logic_unit_arbiter                                           |
// | Brief  : Round-robin arbiter between two requesters sharing one       |
// |          bitwise logic unit. One operation in flight at a time:       |
// |          IDLE (accept) -> EXEC (compute) -> RESP (hold until taken).  |
// | Rev    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------+
module logic_unit_arbiter
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus
);

  logic [1:0]  state_q,      state_d;
  req_t        req_q,        req_d;
  logic        rsp_valid_q,  rsp_valid_d;
  data_t       rsp_data_q,   rsp_data_d;
  logic        rsp_id_q,     rsp_id_d;
  logic [15:0] op_count_q,   op_count_d;
  logic        last_grant_q, last_grant_d;

  logic        grant;
  logic        idle;
  logic        req_hs;
  data_t       result;

  assign idle = (state_q == ST_IDLE);

  // Grant the lone requester, or on a tie the one that did not win last
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end
  end

  // Ready is forced low while reset is held so nothing is accepted then
  assign bus.req0_ready = rst_n & idle & bus.req0_valid & ~grant;
  assign bus.req1_ready = rst_n & idle & bus.req1_valid &  grant;
  assign req_hs         = rst_n & idle & (bus.req0_valid | bus.req1_valid);

  logic_unit u_logic_unit (
    .a_i  (req_q.a),
    .b_i  (req_q.b),
    .op_i (req_q.op),
    .y_o  (result)
  );

  // Next-state: capture in IDLE, compute in EXEC, hold and retire in RESP
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          req_d.a  = grant ? bus.req1_a  : bus.req0_a;
          req_d.b  = grant ? bus.req1_b  : bus.req0_b;
          req_d.op = grant ? bus.req1_op : bus.req0_op;
          req_d.id = grant;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = result;
        rsp_id_d    = req_q.id;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          last_grant_d = rsp_id_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight operation silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = ~idle;
  assign bus.op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_logic_unit_arbiter                                        |
// | Brief  : Scoreboard bench for logic_unit_arbiter. Accepted requests   |
// |          push the expected response; a negedge monitor pops and       |
// |          compares on every response handshake.                        |
// | Rev    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------+
module tb_logic_unit_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_arbiter_if bus();

  logic_unit_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [15:0] a; logic [15:0] b; logic [1:0] op; } op_t;
  typedef struct { logic [15:0] data; logic id; int cyc; } exp_t;

  op_t         q0[$];
  op_t         q1[$];
  exp_t        sb[$];
  logic [15:0] rsp_log[$];
  logic        grant_log[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          acc0   = 0;
  bit          acc1   = 0;
  int          rdy_mode = 0;
  logic        m_last  = 1'b1;
  logic [15:0] m_count = '0;
  logic [15:0] m_data  = '0;
  bit          prev_rst_low = 0;

  // Reference: the four bitwise functions by definition
  function automatic logic [15:0] ref_result(input op_t o);
    case (o.op)
      2'b00:   return o.a & o.b;
      2'b01:   return ~(o.a & o.b);
      2'b10:   return o.a | o.b;
      default: return o.a ^ o.b;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a  = 16'($urandom);
    o.b  = 16'($urandom);
    o.op = 2'($urandom_range(0, 3));
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic log_chk(input string name, input int idx, input logic [15:0] exp);
    if (idx < rsp_log.size()) chk(name, rsp_log[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s: response %0d missing, required %h", name, idx, exp);
    end
  endtask

  task automatic grant_chk(input string name, input int idx, input logic exp);
    if (idx < grant_log.size()) chk(name, grant_log[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s: grant %0d missing, required %0d", name, idx, exp);
    end
  endtask

  task automatic apply_inputs();
    bus.req0_valid = (q0.size() != 0);
    bus.req0_a     = (q0.size() != 0) ? q0[0].a  : 16'h0;
    bus.req0_b     = (q0.size() != 0) ? q0[0].b  : 16'h0;
    bus.req0_op    = (q0.size() != 0) ? q0[0].op : 2'b00;
    bus.req1_valid = (q1.size() != 0);
    bus.req1_a     = (q1.size() != 0) ? q1[0].a  : 16'h0;
    bus.req1_b     = (q1.size() != 0) ? q1[0].b  : 16'h0;
    bus.req1_op    = (q1.size() != 0) ? q1[0].op : 2'b00;
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = 1'($urandom_range(0, 1));
      default: bus.rsp_ready = 1'b0;
    endcase
  endtask

  // Advance one clock; retire accepted operations and drive the next ones
  task automatic step();
    @(posedge clk);
    #1;
    if (acc0) begin
      if (q0.size() != 0) q0.delete(0);
      acc0 = 0;
    end
    if (acc1) begin
      if (q1.size() != 0) q1.delete(0);
      acc1 = 0;
    end
    apply_inputs();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
  endtask

  // Monitor: model-driven expectations for every observable output
  always @(negedge clk) begin : mon
    bit   idle;
    bit   due;
    logic g;
    op_t  o;
    cyc++;
    if (!rst_n) begin
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      if (prev_rst_low) begin
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_op_count", bus.op_count, 0);
      end
      sb.delete();
      m_last = 1'b1;
      m_count = '0;
      m_data = '0;
      prev_rst_low = 1;
    end else begin
      prev_rst_low = 0;
      idle = (sb.size() == 0);
      chk("busy", bus.busy, !idle);
      chk("op_count", bus.op_count, m_count);
      if (!idle) begin
        due = (cyc - sb[0].cyc) >= 2;
        chk("rsp_valid", bus.rsp_valid, due);
        if (due) begin
          chk("rsp_data", bus.rsp_data, sb[0].data);
          chk("rsp_id", bus.rsp_id, sb[0].id);
          if (bus.rsp_valid && bus.rsp_ready) begin
            m_count = m_count + 16'd1;
            m_last  = sb[0].id;
            m_data  = sb[0].data;
            rsp_log.push_back(sb[0].data);
            sb.delete(0);
          end
        end else begin
          chk("rsp_data_hold", bus.rsp_data, m_data);
        end
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
        chk("rsp_data_hold", bus.rsp_data, m_data);
      end
      g = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      chk("req0_ready", bus.req0_ready, idle && bus.req0_valid && !g);
      chk("req1_ready", bus.req1_ready, idle && bus.req1_valid && g);
      if (bus.req0_valid && bus.req0_ready) begin
        o = '{bus.req0_a, bus.req0_b, bus.req0_op};
        sb.push_back('{data: ref_result(o), id: 1'b0, cyc: cyc});
        grant_log.push_back(1'b0);
        acc0 = 1;
      end else if (bus.req1_valid && bus.req1_ready) begin
        o = '{bus.req1_a, bus.req1_b, bus.req1_op};
        sb.push_back('{data: ref_result(o), id: 1'b1, cyc: cyc});
        grant_log.push_back(1'b1);
        acc1 = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset held with both requesters asserting valid: nothing accepted
    rst_n = 1'b0;
    q0.push_back('{16'h1111, 16'h2222, OP_AND});
    q1.push_back('{16'h3333, 16'h4444, OP_OR});
    apply_inputs();
    repeat (3) step();

    // Single AND from requester 0
    q0.delete(); q1.delete();
    q0.push_back('{16'hF0F0, 16'hFF00, OP_AND});
    apply_inputs();
    rsp_log.delete(); grant_log.delete();
    rst_n = 1'b1;
    wait_idle();
    log_chk("single_and_data", 0, 16'hF000);
    grant_chk("single_and_id", 0, 1'b0);
    chk("single_and_count", bus.op_count, 16'd1);

    // Fresh reset, then a tie held for four operations
    rst_n = 1'b0;
    q0.push_back('{16'hFFFF, 16'hFFFF, OP_NAND});
    q0.push_back('{16'h00FF, 16'h0FF0, OP_AND});
    q1.push_back('{16'hAAAA, 16'h5555, OP_XOR});
    q1.push_back('{16'h0F00, 16'h00F0, OP_OR});
    apply_inputs();
    repeat (2) step();
    rsp_log.delete(); grant_log.delete();
    rst_n = 1'b1;
    wait_idle();
    grant_chk("rr_grant0", 0, 1'b0);
    grant_chk("rr_grant1", 1, 1'b1);
    grant_chk("rr_grant2", 2, 1'b0);
    grant_chk("rr_grant3", 3, 1'b1);
    log_chk("rr_data0", 0, 16'h0000);
    log_chk("rr_data1", 1, 16'hFFFF);
    log_chk("rr_data2", 2, 16'h00F0);
    log_chk("rr_data3", 3, 16'h0FF0);

    // All four opcodes on one operand pair
    rsp_log.delete();
    q0.push_back('{16'h0F0F, 16'h00FF, OP_AND});
    q0.push_back('{16'h0F0F, 16'h00FF, OP_NAND});
    q0.push_back('{16'h0F0F, 16'h00FF, OP_OR});
    q0.push_back('{16'h0F0F, 16'h00FF, OP_XOR});
    apply_inputs();
    wait_idle();
    log_chk("op_and", 0, 16'h000F);
    log_chk("op_nand", 1, 16'hFFF0);
    log_chk("op_or", 2, 16'h0FFF);
    log_chk("op_xor", 3, 16'h0FF0);

    // Consumer stalls; other requesters wait, a dropped valid leaves nothing
    rsp_log.delete();
    rdy_mode = 2;
    q1.push_back('{16'h1234, 16'h00FF, OP_OR});
    apply_inputs();
    repeat (3) step();
    q0.push_back('{16'h00F0, 16'h0FF0, OP_AND});
    q1.push_back('{16'hBEEF, 16'h1234, OP_XOR});
    apply_inputs();
    repeat (5) step();
    chk("stall_valid", bus.rsp_valid, 1);
    chk("stall_data", bus.rsp_data, 16'h12FF);
    chk("stall_busy", bus.busy, 1);
    chk("stall_ready0", bus.req0_ready, 0);
    chk("stall_ready1", bus.req1_ready, 0);
    q1.delete();
    apply_inputs();
    step();
    rdy_mode = 0;
    apply_inputs();
    wait_idle();
    chk("stall_rsp_count", rsp_log.size(), 2);
    log_chk("stall_first", 0, 16'h12FF);
    log_chk("stall_second", 1, 16'h00F0);

    // Reset while the operation sits in EXEC
    rsp_log.delete();
    q0.push_back('{16'h5A5A, 16'h0F0F, OP_XOR});
    apply_inputs();
    n = 0;
    while (q0.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("exec_accept_timeout", (n < 20), 1);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("exec_rst_count", bus.op_count, 16'd0);
    chk("exec_rst_data", bus.rsp_data, 16'd0);
    chk("exec_rst_valid", bus.rsp_valid, 0);
    chk("exec_rst_no_rsp", rsp_log.size(), 0);

    // Randomised traffic with a randomly stalling consumer
    rdy_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_op());
      apply_inputs();
      step();
    end
    rdy_mode = 0;
    apply_inputs();
    wait_idle();

    // Counter wrap: preload near the top, then complete operations
    force dut.op_count_q = 16'hFFFD;
    force dut.op_count_d = 16'hFFFD;
    m_count = 16'hFFFD;
    step();
    release dut.op_count_q;
    release dut.op_count_d;
    repeat (3) q0.push_back(rand_op());
    apply_inputs();
    wait_idle();
    chk("wrap_zero", bus.op_count, 16'h0000);
    q1.push_back(rand_op());
    apply_inputs();
    wait_idle();
    chk("wrap_one", bus.op_count, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 The block SHALL use one clock, clk; reset SHALL be rst_n, synchronous and active-low, sampled on the rising edge of clk.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 holds an operation.
REQ-005 req0_ready / req1_ready  output  1  the operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  16  operands.
REQ-007 req0_op / req1_op  input  2  opcode: 00 AND, 01 NAND, 10 OR, 11 XOR.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_data  output  16  result word.
REQ-011 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 op_count  output  16  number of completed response handshakes, modulo 2^16.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-015 IDLE arbitration:
- if only one reqN_valid is high, that requester SHALL be granted;
- if both are high, the requester not equal to last_grant SHALL be granted (round-robin).
REQ-016 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only while its valid is high; it SHALL be combinational from state, valid and last_grant.
REQ-017 On a request handshake (valid & ready), the block SHALL register a, b, op and the requester id, then enter EXEC.
REQ-018 EXEC SHALL last exactly one cycle. It SHALL compute the result bitwise over 16 bits and register it into rsp_data, set rsp_valid, and enter RESP.
REQ-019 rsp_valid SHALL first be high in the second cycle after the request handshake cycle.
REQ-020 In RESP, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_valid & rsp_ready.
REQ-021 On the response handshake, the block SHALL:
- clear rsp_valid;
- increment op_count;
- set last_grant to rsp_id;
- return to IDLE.
REQ-022 No request SHALL be accepted in EXEC or RESP; the minimum spacing between accepted requests SHALL be three cycles.
REQ-023 rsp_data SHALL retain its last value after the response handshake until the next EXEC.
REQ-024 op_count SHALL wrap from 0xFFFF to 0x0000 without any flag.
REQ-025 Requesters SHALL hold valid and operands until ready; a valid dropped before ready SHALL leave no state behind.

Reset
REQ-026 While rst_n is low at a clock edge, the block SHALL set:
- state to IDLE;
- rsp_valid, rsp_data, rsp_id, busy and op_count to 0;
- last_grant to 1, so requester 0 wins the first tie.
REQ-027 Both reqN_ready outputs SHALL be low during any cycle in which rst_n is low.
REQ-028 A reset during EXEC or RESP SHALL discard the in-flight operation with no response and no count increment.

Structure
REQ-029 Shared package alu_pkg SHALL hold:
- the 2-bit opcode constants (OP_AND, OP_NAND, OP_OR, OP_XOR);
- the FSM state encoding;
- the 16-bit data width constant.
REQ-030 The bitwise computation SHALL live in one combinational sub-module, logic_unit (16-bit a, b, 2-bit op, 16-bit y), instantiated once.
REQ-031 The arbiter, FSM, registers and counter SHALL reside in logic_unit_arbiter.

Verification
REQ-032 After reset, req0 AND with a=0xF0F0, b=0xFF00 and rsp_ready=1 -> req0_ready high in the same cycle; two cycles later rsp_valid=1, rsp_data=0xF000, rsp_id=0; op_count=1 after the handshake.
REQ-033 After reset, both valid:
- req0 NAND 0xFFFF, 0xFFFF;
- req1 XOR 0xAAAA, 0x5555;
-> first response id 0 with data 0x0000, second id 1 with data 0xFFFF. Holding both valid for four operations -> grant order 0, 1, 0, 1.
REQ-034 req1 OR 0x1234, 0x00FF with rsp_ready low for 5 cycles -> rsp_valid=1 and rsp_data=0x12FF held stable; both reqN_ready stay low; busy=1 throughout.
REQ-035 Reset asserted during EXEC -> at the next edge state=IDLE, rsp_valid=0, rsp_data=0, op_count=0; no response appears.
REQ-036 65536 back-to-back completed operations -> op_count reads 0x0000 afterwards; one further operation reads 0x0001.
REQ-037 All four opcodes with a=0x0F0F, b=0x00FF -> results 0x000F (AND), 0xFFF0 (NAND), 0x0FFF (OR), 0x0FF0 (XOR).
